// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus: requester handshake lanes plus the registered register-file write port.
interface rf_wb_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [5*NREQ-1:0]    req_addr;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [4:0]           rf_waddr;
    logic [31:0]          rf_wdata;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// The winning write is registered once; x0 writes are accepted but never raise rf_we.
module rf_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    rf_wb_arbiter_if.slave   bus,
    output logic [CNT_W-1:0] cont_cnt
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             rf_we_q, rf_we_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [31:0]      rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0] cont_cnt_q, cont_cnt_d;

    logic [NREQ-1:0]  grant_oh;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic [4:0]       win_addr;
    logic [31:0]      win_data;
    int               cand;
    int               n_valid;

    // Wrap is an explicit subtract so non-power-of-two NREQ stays in range.
    always_comb begin
        grant_oh     = '0;
        grant_idx    = last_grant_q;
        grant_vld    = 1'b0;
        cand         = 0;
        n_valid      = 0;
        win_addr     = '0;
        win_data     = '0;
        last_grant_d = last_grant_q;
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        cont_cnt_d   = cont_cnt_q;

        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(last_grant_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!grant_vld && en && !rst && bus.req_valid[cand]) begin
                grant_vld = 1'b1;
                grant_idx = IDX_W'(cand);
            end
        end

        for (int i = 0; i < NREQ; i++) begin
            if (bus.req_valid[i]) n_valid = n_valid + 1;
        end

        if (grant_vld) begin
            grant_oh[grant_idx] = 1'b1;
            win_addr     = bus.req_addr[5*int'(grant_idx) +: 5];
            win_data     = bus.req_data[32*int'(grant_idx) +: 32];
            last_grant_d = grant_idx;
            rf_we_d      = (win_addr != 5'd0);
            rf_waddr_d   = win_addr;
            rf_wdata_d   = win_data;
        end

        if (en && n_valid >= 2) cont_cnt_d = cont_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= IDX_W'(NREQ - 1);
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            cont_cnt_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            cont_cnt_q   <= cont_cnt_d;
        end
    end

    assign bus.req_ready = grant_oh;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign cont_cnt      = cont_cnt_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected writes are queued at issue time and
// checked by an independent monitor whenever the register-file write port fires.
module tb_rf_wb_arbiter;
    localparam int NREQ  = 3;
    localparam int CNT_W = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic [CNT_W-1:0] cont_cnt;

    wr_t sb[$];
    int  compared;
    int  mismatched;

    logic [31:0] d0, d1, d2;

    rf_wb_arbiter_if #(.NREQ(NREQ)) bus ();

    rf_wb_arbiter #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bus      (bus),
        .cont_cnt (cont_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] v,
                                 input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                                 input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2);
        bus.req_valid = v;
        bus.req_addr  = {a2, a1, a0};
        bus.req_data  = {x2, x1, x0};
        #1;
    endtask

    task automatic expectWrite(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        sb.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset lands between edges; any queued write it kills is dropped from the scoreboard.
    task automatic resetPulse();
        @(posedge clk);
        #3 rst = 1'b1;
        sb.delete();
        #4 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.rf_we) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                         bus.rf_waddr, bus.rf_wdata);
            end else begin
                wr_t w;
                w = sb.pop_front();
                checkOutput("rf_waddr", 32'(bus.rf_waddr), 32'(w.addr));
                checkOutput("rf_wdata", bus.rf_wdata, w.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        d0 = 32'hA000_0000;
        d1 = 32'hB111_1111;
        d2 = 32'hC222_2222;
        rst = 1'b1;
        en  = 1'b1;
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, d0, d1, d2);
        #2;
        checkOutput("ready_in_reset", 32'(bus.req_ready), 32'd0);
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("reset_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        checkOutput("reset_rf_wdata", bus.rf_wdata, 32'd0);
        checkOutput("reset_cont_cnt", 32'(cont_cnt), 32'd0);

        // Single request from requester 0
        tick();
        applyStimulus(3'b001, 5'd5, 5'd0, 5'd0, 32'hDEADBEEF, 32'd0, 32'd0);
        checkOutput("single_ready", 32'(bus.req_ready), 32'b001);
        expectWrite(5'd5, 32'hDEADBEEF);
        tick();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("single_we_high", 32'(bus.rf_we), 32'd1);
        tick();
        checkOutput("single_we_low", 32'(bus.rf_we), 32'd0);

        // Round-robin among three persistent requesters
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        resetPulse();
        applyStimulus(3'b111, 5'd1, 5'd2, 5'd3, d0, d1, d2);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("rr_ready_%0d", k), 32'(bus.req_ready), 32'(1 << (k % 3)));
            case (k % 3)
                0: expectWrite(5'd1, d0);
                1: expectWrite(5'd2, d1);
                default: expectWrite(5'd3, d2);
            endcase
            tick();
        end
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("rr_cont_cnt", 32'(cont_cnt), 32'd6);
        tick();

        // x0 write is accepted but dropped; next search starts at requester 2
        applyStimulus(3'b010, 5'd0, 5'd0, 5'd0, 32'd0, 32'h12345678, 32'd0);
        checkOutput("x0_ready", 32'(bus.req_ready), 32'b010);
        tick();
        checkOutput("x0_no_we", 32'(bus.rf_we), 32'd0);
        applyStimulus(3'b111, 5'd7, 5'd8, 5'd9, d0, d1, d2);
        checkOutput("after_x0_ready", 32'(bus.req_ready), 32'b100);
        expectWrite(5'd9, d2);
        tick();
        checkOutput("after_x0_cont", 32'(cont_cnt), 32'd7);

        // Freeze with all requesters pending
        en = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("freeze_ready_%0d", k), 32'(bus.req_ready), 32'd0);
            tick();
            checkOutput($sformatf("freeze_we_%0d", k), 32'(bus.rf_we), 32'd0);
        end
        checkOutput("freeze_cont", 32'(cont_cnt), 32'd7);
        en = 1'b1;
        #1;
        checkOutput("unfreeze_ready", 32'(bus.req_ready), 32'b001);
        expectWrite(5'd7, d0);
        tick();
        checkOutput("unfreeze_cont", 32'(cont_cnt), 32'd8);
        checkOutput("unfreeze_we", 32'(bus.rf_we), 32'd1);

        // Async reset while a write is pending on the port
        #2 rst = 1'b1;
        sb.delete();
        #1;
        checkOutput("async_rf_we", 32'(bus.rf_we), 32'd0);
        checkOutput("async_rf_waddr", 32'(bus.rf_waddr), 32'd0);
        checkOutput("async_rf_wdata", bus.rf_wdata, 32'd0);
        checkOutput("async_cont", 32'(cont_cnt), 32'd0);
        checkOutput("async_ready", 32'(bus.req_ready), 32'd0);
        #2 rst = 1'b0;
        #1;
        checkOutput("post_reset_ready", 32'(bus.req_ready), 32'b001);
        expectWrite(5'd7, d0);
        tick();
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();

        // Counter wrap: 17 contention cycles on a 4-bit counter
        resetPulse();
        applyStimulus(3'b011, 5'd10, 5'd11, 5'd0, d0, d1, 32'd0);
        for (int k = 0; k < 17; k++) begin
            checkOutput($sformatf("wrap_ready_%0d", k), 32'(bus.req_ready),
                        (k % 2 == 0) ? 32'b001 : 32'b010);
            if (k % 2 == 0) expectWrite(5'd10, d0);
            else            expectWrite(5'd11, d1);
            tick();
        end
        applyStimulus(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        checkOutput("wrap_cont", 32'(cont_cnt), 32'd1);
        tick();
        tick();
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
